// File: rtl/mm_pkg.sv
// Shared types and the saturate/ReLU transform used by the matrix-vector multiplier datapath.
//   ACC_W   signed accumulator width of dot-product results
//   OUT_W   signed width of collected results
//   VEC_LEN results per output vector
package mm_pkg;

  localparam int unsigned ACC_W   = 16;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned VEC_LEN = 3;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] res_t;

  // One buffered result: data plus end-of-vector tag
  typedef struct packed {
    logic last;
    res_t data;
  } fifo_entry_t;

  // Transform result: narrowed value and whether saturation clipped it
  typedef struct packed {
    res_t value;
    logic clipped;
  } sat_relu_t;

  localparam acc_t SAT_MAX = acc_t'((2 ** (int'(OUT_W) - 1)) - 1);
  localparam acc_t SAT_MIN = acc_t'(-(2 ** (int'(OUT_W) - 1)));

  // ReLU first, then clip into the OUT_W signed range; ReLU zeroing never counts as a clip
  function automatic sat_relu_t sat_relu(input acc_t x, input logic relu);
    acc_t      v;
    sat_relu_t r;
    v         = (relu && (x < 0)) ? '0 : x;
    r.value   = res_t'(v);
    r.clipped = 1'b0;
    if (v > SAT_MAX) begin
      r.value   = res_t'(SAT_MAX);
      r.clipped = 1'b1;
    end else if (v < SAT_MIN) begin
      r.value   = res_t'(SAT_MIN);
      r.clipped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mm_sync_fifo.sv
// Generic DEPTH x W register FIFO with occupancy count. Caller guarantees push only when
// not full and pop only when not empty. Storage is not reset; head is read combinationally.
//   clk, rst  clock, synchronous active-high reset
//   push      write wdata at the tail
//   pop       drop the head entry
//   wdata     tail write data
//   rdata     head data (mem[rd_ptr])
//   count     number of valid entries, 0..DEPTH
module mm_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, deliberately without reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/mvm_result_collector.sv
// Collects scalar dot-product results from the multiplier, applies optional ReLU and
// saturation, buffers them and tags the last element of every VEC_LEN-element vector.
//   clk, rst      clock, synchronous active-high reset
//   in_valid/in_data/in_ready   result handshake from the multiplier
//   relu_en       zero negative results, sampled per accepted beat
//   out_valid/out_data/out_last/out_ready   buffered result handshake to the sink
//   sat_flag      sticky clip indicator, cleared by clear_flag
//   vec_done_cnt  vectors fully delivered, wraps at 255
module mvm_result_collector
  import mm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [ACC_W-1:0] in_data,
  output logic             in_ready,
  input  logic             relu_en,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sat_flag,
  input  logic             clear_flag,
  output logic [7:0]       vec_done_cnt
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  typedef enum logic {
    ST_EMPTY,
    ST_ACTIVE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] elem_idx;
  logic             push;
  logic             pop;
  sat_relu_t        xf;
  fifo_entry_t      wr_entry;
  fifo_entry_t      rd_entry;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Transform and tag the incoming beat
  assign xf             = sat_relu(acc_t'(in_data), relu_en);
  assign wr_entry.data  = xf.value;
  assign wr_entry.last  = (elem_idx == IDX_W'(VEC_LEN - 1));

  mm_sync_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fifo_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count)
  );

  // Head data; last is masked while empty because storage is never reset
  assign out_data = rd_entry.data;
  assign out_last = rd_entry.last & out_valid;

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Controller next state and handshake decode; in_ready depends only on registered count
  always_comb begin
    state_d   = state_q;
    out_valid = (state_q == ST_ACTIVE);
    in_ready  = (count != CNT_W'(DEPTH));
    case (state_q)
      ST_EMPTY:  if (push) state_d = ST_ACTIVE;
      ST_ACTIVE: if (pop && !push && (count == CNT_W'(1))) state_d = ST_EMPTY;
      default:   state_d = ST_EMPTY;
    endcase
  end

  // Position of the next pushed element within its vector
  always_ff @(posedge clk) begin
    if (rst) begin
      elem_idx <= '0;
    end else if (push) begin
      if (elem_idx == IDX_W'(VEC_LEN - 1)) elem_idx <= '0;
      else                                 elem_idx <= elem_idx + IDX_W'(1);
    end
  end

  // Sticky clip flag; clear has priority over a same-cycle set
  always_ff @(posedge clk) begin
    if (rst)                     sat_flag <= 1'b0;
    else if (clear_flag)         sat_flag <= 1'b0;
    else if (push && xf.clipped) sat_flag <= 1'b1;
  end

  // Completed-vector counter
  always_ff @(posedge clk) begin
    if (rst)                  vec_done_cnt <= '0;
    else if (pop && out_last) vec_done_cnt <= vec_done_cnt + 8'd1;
  end

endmodule

// File: tb/tb_mvm_result_collector.sv
// Directed and randomized bench for mvm_result_collector against a queue-based reference model.
module tb_mvm_result_collector;

  localparam int DEPTH   = 4;
  localparam int VEC_LEN = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        relu_en;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic        sat_flag;
  logic        clear_flag;
  logic [7:0]  vec_done_cnt;

  always #5 clk = ~clk;

  mvm_result_collector #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .relu_en      (relu_en),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .sat_flag     (sat_flag),
    .clear_flag   (clear_flag),
    .vec_done_cnt (vec_done_cnt)
  );

  // Reference model state
  typedef struct {
    int data;
    bit last;
  } ent_t;

  ent_t       q[$];
  int         m_pushes;
  bit         m_sat;
  logic [7:0] m_vec;
  bit         m_push;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // ReLU then clip to signed 8-bit range, in plain integer arithmetic
  function automatic int xform(input int x, input bit relu, output bit clip);
    int v;
    v    = (relu && x < 0) ? 0 : x;
    clip = 1'b0;
    if (v > 127)  begin v = 127;  clip = 1'b1; end
    if (v < -128) begin v = -128; clip = 1'b1; end
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pushes = 0;
    m_sat    = 1'b0;
    m_vec    = 8'd0;
  endtask

  // One clock: drive on the falling edge, compare outputs, then advance the model on the rising edge
  task automatic cyc(input bit iv, input int d, input bit re, input bit ordy, input bit clr, input bit rs);
    bit         m_pop;
    bit         clip;
    int         v;
    logic [7:0] exp_d;
    @(negedge clk);
    rst        = rs;
    in_valid   = iv;
    in_data    = 16'(d);
    relu_en    = re;
    out_ready  = ordy;
    clear_flag = clr;
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("sat_flag", 32'(sat_flag), 32'(m_sat));
    chk("vec_done_cnt", 32'(vec_done_cnt), 32'(m_vec));
    if (q.size() != 0) begin
      exp_d = 8'(q[0].data);
      chk("out_data", 32'(out_data), 32'(exp_d));
      chk("out_last", 32'(out_last), 32'(q[0].last));
    end else begin
      chk("out_last_empty", 32'(out_last), 32'd0);
    end
    m_push = iv && (q.size() < DEPTH);
    m_pop  = ordy && (q.size() != 0);
    @(posedge clk);
    if (rs) begin
      model_reset();
      m_push = 1'b0;
    end else begin
      clip = 1'b0;
      if (m_pop) begin
        if (q[0].last) m_vec = m_vec + 8'd1;
        void'(q.pop_front());
      end
      if (m_push) begin
        v = xform($signed(16'(d)), re, clip);
        q.push_back('{data: v, last: ((m_pushes % VEC_LEN) == VEC_LEN - 1)});
        m_pushes++;
      end
      if (clr)                 m_sat = 1'b0;
      else if (m_push && clip) m_sat = 1'b1;
    end
  endtask

  // Upstream must hold a refused beat stable
  logic        pv   = 1'b0;
  logic [15:0] pd   = '0;
  logic        pacc = 1'b0;
  logic        prst = 1'b1;
  always @(posedge clk) begin
    if (pv && !pacc && !prst && !rst)
      assert (in_valid && in_data == pd)
      else $error("FAIL proto observed valid=%0b data=%0d expected held data=%0d", in_valid, in_data, pd);
    pv   <= in_valid;
    pd   <= in_data;
    pacc <= in_valid && in_ready;
    prst <= rst;
  end

  initial begin
    bit   pend;
    int   pdata;
    bit   rs;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; relu_en = 1'b0;
    out_ready = 1'b0; clear_flag = 1'b0;
    model_reset();

    // Reset then idle
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);

    // One vector with a ready sink
    cyc(1, 10, 0, 1, 0, 0);
    cyc(1, 20, 0, 1, 0, 0);
    cyc(1, 30, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1, 0, 0);
    chk("vec_after_first", 32'(vec_done_cnt), 32'd1);

    // Fill against a stalled sink; fifth beat is held until space frees up
    for (int k = 1; k <= 4; k++) cyc(1, k, 0, 0, 0, 0);
    cyc(1, 5, 0, 0, 0, 0);
    cyc(1, 5, 0, 1, 0, 0);
    cyc(1, 5, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 0);

    // Saturation, clear, ReLU
    cyc(1, 300, 0, 1, 0, 0);
    cyc(1, -300, 0, 1, 0, 0);
    cyc(1, 50, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(1, -5, 1, 1, 0, 0);
    cyc(1, -300, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);

    // Steady push+pop at two entries
    cyc(1, 100, 0, 0, 0, 0);
    cyc(1, 101, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 102 + i, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);

    // Reset mid-vector with buffered data
    cyc(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) cyc(1, 40 + k, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 7, 0, 1, 0, 0);
    cyc(1, 8, 0, 1, 0, 0);
    cyc(1, 9, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1, 0, 0);

    // Randomized traffic
    pend  = 1'b0;
    pdata = 0;
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 99) == 0);
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend  = 1'b1;
        pdata = int'($urandom_range(0, 1400)) - 700;
      end
      cyc(pend, pend ? pdata : 0, bit'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 15) == 0), rs);
      if (rs || m_push) pend = 1'b0;
    end
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
